// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the UART receive path
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// rtl/uart_rx_ctrl_sync.sv - multi-flop synchronizer for the asynchronous rx pin
module synchronizer #(
  parameter int FF_NUM = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [FF_NUM-1:0] sync_q;
  logic [FF_NUM-1:0] sync_d;

  // shift the raw input one stage deeper each cycle
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = d;
  end

  // chain presets high so a reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[FF_NUM-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive frame controller; UART_RX_PARITY_EN adds a parity bit and parity_err
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_FF      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  input  logic                 rx_parity_odd,
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic rx_s;
  logic sync_rst;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 commit;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_bad;
`endif

  assign sync_rst = ~reset_n;

  synchronizer #(
    .FF_NUM(SYNC_FF)
  ) u_rx_sync (
    .clk(clk),
    .rst(sync_rst),
    .d  (rx_in),
    .q  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  // received ones plus parity bit must match the selected odd/even sense
  assign par_bad = ((^shreg_q) ^ par_bit_q) != rx_parity_odd;
`endif

  // frame sequencer, sample points and output-register commit rules
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 1'b1;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IW'(i)) begin
              shreg_d[i] = rx_s;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              parity_err_d = 1'b1;
            end else begin
              commit = 1'b1;
            end
`else
            commit = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        bit_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    // a consumer draining the old word in the same cycle makes room for the new one
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // state, counters and output register; reset drops any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_CPB = CPB;
`else
  localparam int PAR_CPB = 0;
`endif
  // posedges from the start-bit launch edge to the commit edge
  localparam int COMMIT_EDGE = 2 + 1 + CPB / 2 + 9 * CPB + PAR_CPB;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_odd;
  logic       parity_err;
  int         n_perr = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_hs = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_hs;
    int         exp_ferr;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .SYNC_FF     (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
`ifdef UART_RX_PARITY_EN
    .rx_parity_odd(rx_parity_odd),
    .parity_err   (parity_err),
`endif
    .busy         (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // drives one frame; the stop-bit level is left on the line afterwards
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_in = d[i];
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx_in = (^d) ^ rx_parity_odd ^ par_flip;
    repeat (CPB) @(posedge clk);
`else
    if (par_flip) begin
      rx_in = 1'b1;
    end
`endif
    #1 rx_in = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // scoreboard: pop and compare on every handshake, tally flag pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got data %0h with no word expected", rx_data);
        end else begin
          chk("rx_data_sb", rx_data, exp_q.pop_front());
        end
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err || overrun) chk("ferr_ovr_excl", frame_err & overrun, 0);
`ifdef UART_RX_PARITY_EN
      if (parity_err) n_perr++;
`endif
    end
  end

  initial begin
    int hs0, fe0, ov0, bcnt;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'hF0, 1'b0, 0, 1};
    vecs[6] = '{8'h01, 1'b1, 1, 0};

    reset_n  = 1'b0;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
`ifdef UART_RX_PARITY_EN
    rx_parity_odd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // table of frames received with rx_ready held high
    for (int i = 0; i < 7; i++) begin
      hs0 = n_hs; fe0 = n_ferr; ov0 = n_ovr;
      if (vecs[i].exp_hs != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop_bit, 1'b0);
      rx_in = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_hs", i), n_hs - hs0, vecs[i].exp_hs);
      chk($sformatf("vec%0d_ferr", i), n_ferr - fe0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i), n_ovr - ov0, 0);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end

    // short low glitch on an idle line
    hs0 = n_hs; fe0 = n_ferr; bcnt = 0;
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    chk_range("glitch_busy_cycles", bcnt, 1, 10);
    chk("glitch_hs", n_hs - hs0, 0);
    chk("glitch_ferr", n_ferr - fe0, 0);
    chk("glitch_valid", rx_valid, 0);

    // bad stop bit followed by a held break
    hs0 = n_hs; fe0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("break_busy_low", busy, 1);
    rx_in = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("break_busy_released", busy, 0);
    chk("break_ferr", n_ferr - fe0, 1);
    chk("break_hs", n_hs - hs0, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("after_break_hs", n_hs - hs0, 1);

    // overrun while the consumer stalls
    rx_ready = 1'b0;
    ov0 = n_ovr; fe0 = n_ferr;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", rx_valid, 1);
    chk("hold_data", rx_data, 8'h01);
    send_frame(8'h02, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovr_count", n_ovr - ov0, 1);
    chk("ovr_data_kept", rx_data, 8'h01);
    chk("ovr_valid_kept", rx_valid, 1);
    chk("ovr_no_ferr", n_ferr - fe0, 0);

    // consumer accepts exactly on the commit cycle of the next frame
    ov0 = n_ovr; hs0 = n_hs;
    exp_q.push_back(8'h7E);
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        repeat (COMMIT_EDGE) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("swap_valid", rx_valid, 1);
    chk("swap_data", rx_data, 8'h7E);
    chk("swap_no_ovr", n_ovr - ov0, 0);
    chk("swap_old_taken", n_hs - hs0, 1);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("swap_drained", rx_valid, 0);

    // reset in the middle of a frame while a word is held
    rx_ready = 1'b0;
    exp_q.push_back(8'h33);
    send_frame(8'h33, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (60) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_flags", {frame_err, overrun}, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
      end
    join
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    hs0 = n_hs;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("postrst_hs", n_hs - hs0, 1);

`ifdef UART_RX_PARITY_EN
    hs0 = n_hs;
    fe0 = n_perr;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("par_err_count", n_perr - fe0, 1);
    chk("par_err_hs", n_hs - hs0, 0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
